aes_round_controller: RTL and testbench
=======================================

Name: aes_round_controller

Overview:
- Sequencing FSM for the byte-serial AES-128 datapath core.
- Accepts a block-start request, issues the per-byte inner-state counter, round number, mode, first-round and synchronous-clear strobes to the datapath and key schedule.
- Marks the 16 ciphertext/plaintext output bytes with valid/last strobes.
- Sits between the user-side byte interface and the datapath core / key-schedule pair.

Parameters:
- NUM_ROUNDS, 10, number of AES rounds after the initial key addition (AES-128); legal range 2..14.
- OUT_LATENCY, 2, cycles between a final-round byte slot and that byte appearing on the datapath output; legal range 0..7.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- start  input  1  request to process one 16-byte block; sampled only in IDLE
- encrypt_in  input  1  mode for the requested block: 1 = encrypt, 0 = decrypt
- abort  input  1  synchronous abort of the current block
- busy  output  1  high in every state except IDLE
- in_ready  output  1  high during the 16 LOAD cycles; the user drives data_in byte i while inner_state_counter == i
- inner_state_counter  output  4  byte slot within the current round, 0..15
- round_num  output  4  0 during LOAD, 1..NUM_ROUNDS during rounds; to key schedule
- encrypt  output  1  latched mode, stable for the whole block
- first_round  output  1  high during the LOAD cycles only
- rst_synch  output  1  one-cycle clear of the datapath permutation/state registers
- key_start  output  1  one-cycle restart of the key schedule, coincident with rst_synch
- out_valid  output  1  datapath output byte valid
- out_last  output  1  qualifies the 16th output byte
- done  output  1  one-cycle pulse, equals out_last

Behaviour:
- All outputs are registered.
- Reset (rst == 0 at an edge):
  - state IDLE; all outputs 0 except encrypt = 1.
  - The delay line is cleared.
- States: IDLE, PREP, LOAD, ROUND, FINAL, DRAIN.
- IDLE:
  - counter and round_num held at 0.
  - On start == 1: latch encrypt_in into encrypt, then go to PREP.
- PREP (1 cycle): rst_synch = key_start = 1, then go to LOAD.
- LOAD (16 cycles):
  - first_round = 1, in_ready = 1, round_num = 0.
  - counter runs 0..15.
  - At 15: round_num becomes 1 and the next state is ROUND, or FINAL if NUM_ROUNDS == 1 (NUM_ROUNDS == 1 is excluded by the parameter range).
- ROUND (16 cycles per round, rounds 1..NUM_ROUNDS-1):
  - counter wraps 15 -> 0 and round_num increments at the wrap.
  - Leaving round NUM_ROUNDS-1 goes to FINAL.
- FINAL (16 cycles, round_num = NUM_ROUNDS):
  - Each cycle pushes a slot strobe into an OUT_LATENCY-deep shift register.
  - The slot at counter 15 also carries a last flag.
  - out_valid and out_last are the shift-register taps; with OUT_LATENCY = 0 they coincide with FINAL.
- DRAIN (OUT_LATENCY cycles):
  - counter held at 0; the delay line is flushed.
  - Next state is IDLE in the cycle after out_last. Skipped if OUT_LATENCY = 0.
- Timing, start sampled at edge 0:
  - PREP cycle 1; LOAD cycles 2..17.
  - Round r occupies cycles 2+16r .. 17+16r.
  - out_valid covers cycles 2+16·NUM_ROUNDS+OUT_LATENCY .. 17+16·NUM_ROUNDS+OUT_LATENCY.
  - busy falls the cycle after done.
  - Defaults: out_last/done at cycle 179, busy low at 180.
- start while busy is ignored, not queued.
- start in the same cycle that busy falls is accepted: back-to-back blocks, no idle gap beyond that one cycle.
- encrypt_in is ignored outside IDLE; encrypt never changes mid-block.
- abort (any non-IDLE state):
  - Next cycle: state IDLE, rst_synch = key_start = 1 for that one cycle.
  - Delay line cleared; out_valid, out_last and done forced 0 from that cycle.
  - No done pulse for the aborted block.
- abort and start together in IDLE: abort has no effect and start is accepted.
- Reset mid-block behaves as abort except that rst_synch/key_start stay 0. The datapath receives the same rst.

Decomposition:
- Package aes_ctrl_pkg:
  - state enum: IDLE, PREP, LOAD, ROUND, FINAL, DRAIN.
  - AES_BYTES_PER_BLOCK = 16, AES_BYTE_IDX_W = 4, AES128_NUM_ROUNDS = 10.
- One sub-module, aes_valid_delay: parameterised OUT_LATENCY-deep shift register carrying {valid, last}, synchronous active-low reset plus synchronous clear input; pure wire when depth is 0.

Test Plan:
- Reset then single encrypt block, defaults:
  - encrypt = 1 held 162 cycles.
  - in_ready high cycles 2..17.
  - round_num steps 0,1..10 at cycles 2,18..162.
  - 16 out_valid cycles 164..179; out_last/done at 179 only.
- Decrypt block: encrypt_in = 0 at start, toggled to 1 mid-block -> encrypt stays 0 until IDLE; same timing.
- Back-to-back:
  - start held high continuously -> second PREP at cycle 181, rst_synch pulses at 1 and 181.
  - No start accepted between.
- Abort in round 5, counter 7 -> next cycle IDLE, rst_synch and key_start each high one cycle, no out_valid/done; a new start 3 cycles later runs a full block.
- Parameter sweep OUT_LATENCY = 0 and 7, NUM_ROUNDS = 14:
  - out_valid spans exactly 16 cycles starting 2+16·NUM_ROUNDS+OUT_LATENCY.
  - busy falls the cycle after out_last.
- rst = 0 asserted at cycle 100 for 1 cycle -> all outputs 0 and encrypt = 1 the next cycle; start ignored while rst = 0.

Source files
------------

// File: rtl/aes_round_controller_pkg.sv
// Shared types and constants for the byte-serial AES-128 round controller.
package aes_ctrl_pkg;

  localparam int AES_BYTES_PER_BLOCK = 16;
  localparam int AES_BYTE_IDX_W      = 4;
  localparam int AES128_NUM_ROUNDS   = 10;
  localparam int ROUND_NUM_W         = 4;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    LOAD,
    ROUND,
    FINAL,
    DRAIN
  } ctrl_state_e;

  typedef logic [AES_BYTE_IDX_W-1:0] byte_idx_t;
  typedef logic [ROUND_NUM_W-1:0]    round_num_t;

  // One output-byte slot travelling through the latency-matching delay line.
  typedef struct packed {
    logic valid;
    logic last;
  } out_slot_t;

  // Registered control outputs that follow the FSM directly.
  typedef struct packed {
    logic       busy;
    logic       in_ready;
    byte_idx_t  cnt;
    round_num_t round_num;
    logic       encrypt;
    logic       first_round;
    logic       rst_synch;
    logic       key_start;
  } ctrl_out_t;

  // Encrypt is the default mode after reset; everything else is quiet.
  localparam ctrl_out_t CTRL_OUT_RESET = '{
    busy:        1'b0,
    in_ready:    1'b0,
    cnt:         '0,
    round_num:   '0,
    encrypt:     1'b1,
    first_round: 1'b0,
    rst_synch:   1'b0,
    key_start:   1'b0
  };

  // True on the 16th byte slot of a round.
  function automatic logic is_last_byte(input byte_idx_t idx);
    return idx == byte_idx_t'(AES_BYTES_PER_BLOCK - 1);
  endfunction

endpackage

// File: rtl/aes_round_controller_if.sv
// User-side handshake plus datapath/key-schedule control bundle of the
// AES round controller. The master drives block requests, the slave is
// the controller itself.
interface aes_round_controller_if;
  import aes_ctrl_pkg::*;

  logic       start;
  logic       encrypt_in;
  logic       abort;
  logic       busy;
  logic       in_ready;
  byte_idx_t  inner_state_counter;
  round_num_t round_num;
  logic       encrypt;
  logic       first_round;
  logic       rst_synch;
  logic       key_start;
  logic       out_valid;
  logic       out_last;
  logic       done;

  modport master (
    output start, encrypt_in, abort,
    input  busy, in_ready, inner_state_counter, round_num, encrypt,
           first_round, rst_synch, key_start, out_valid, out_last, done
  );

  modport slave (
    input  start, encrypt_in, abort,
    output busy, in_ready, inner_state_counter, round_num, encrypt,
           first_round, rst_synch, key_start, out_valid, out_last, done
  );

endinterface

// File: rtl/aes_round_controller_valid_delay.sv
// DEPTH-stage shift register carrying {valid, last} so the output strobes
// line up with the datapath's output latency. Collapses to a wire at depth 0.
module aes_valid_delay
  import aes_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_clr,
  input  out_slot_t i_slot,
  output out_slot_t o_slot
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = ^{clk, rst, i_clr};
    assign o_slot   = i_slot;
  end else begin : g_sr
    out_slot_t r_sr [DEPTH];

    // Shift slots one stage per cycle; flush on reset or abort.
    always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every stage sample its
      // predecessor's pre-edge value, so the chain really shifts by one.
      if (!rst || i_clr) begin
        // NOTE: this array is tiny and must be flushed on abort, so each
        // entry is reset explicitly; a real RAM would not be reset this way.
        for (int i = 0; i < DEPTH; i++) begin
          r_sr[i] <= '0;
        end
      end else begin
        r_sr[0] <= i_slot;
        for (int i = 1; i < DEPTH; i++) begin
          r_sr[i] <= r_sr[i-1];
        end
      end
    end

    assign o_slot = r_sr[DEPTH-1];
  end

endmodule

// File: rtl/aes_round_controller.sv
// Sequencing FSM for the byte-serial AES-128 datapath: PREP clears the
// datapath and restarts the key schedule, LOAD takes 16 input bytes, then
// NUM_ROUNDS rounds of 16 byte slots follow. Bytes of the final round are
// marked valid/last after OUT_LATENCY cycles, DRAIN waits for the last one.
module aes_round_controller
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS  = AES128_NUM_ROUNDS, // legal 2..14
  parameter int OUT_LATENCY = 2                  // legal 0..7
) (
  input logic                  clk,
  input logic                  rst,
  aes_round_controller_if.slave bus
);

  localparam round_num_t PENULT_ROUND = round_num_t'(NUM_ROUNDS - 1);

  ctrl_state_e r_state;
  ctrl_state_e w_state_nxt;
  ctrl_out_t   r_out;
  ctrl_out_t   w_out_nxt;
  logic        r_out_valid;
  logic        r_out_last;
  logic        w_abort;
  out_slot_t   w_slot_in;
  out_slot_t   w_slot_dly;

  // Abort only matters while a block is in flight; in IDLE start wins.
  assign w_abort = bus.abort && (r_state != IDLE);

  // Next state and next registered control outputs.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave a value unassigned and infer a latch.
    w_state_nxt         = r_state;
    w_out_nxt           = r_out;
    w_out_nxt.rst_synch = 1'b0;
    w_out_nxt.key_start = 1'b0;

    case (r_state)
      IDLE: begin
        w_out_nxt.cnt       = '0;
        w_out_nxt.round_num = '0;
        if (bus.start) begin
          w_state_nxt         = PREP;
          w_out_nxt.encrypt   = bus.encrypt_in;
          w_out_nxt.rst_synch = 1'b1;
          w_out_nxt.key_start = 1'b1;
        end
      end

      PREP: begin
        w_state_nxt         = LOAD;
        w_out_nxt.cnt       = '0;
        w_out_nxt.round_num = '0;
      end

      LOAD: begin
        if (is_last_byte(r_out.cnt)) begin
          w_out_nxt.cnt       = '0;
          w_out_nxt.round_num = round_num_t'(1);
          w_state_nxt         = (NUM_ROUNDS == 1) ? FINAL : ROUND;
        end else begin
          w_out_nxt.cnt = r_out.cnt + byte_idx_t'(1);
        end
      end

      ROUND: begin
        if (is_last_byte(r_out.cnt)) begin
          w_out_nxt.cnt       = '0;
          w_out_nxt.round_num = r_out.round_num + round_num_t'(1);
          if (r_out.round_num == PENULT_ROUND) begin
            w_state_nxt = FINAL;
          end
        end else begin
          w_out_nxt.cnt = r_out.cnt + byte_idx_t'(1);
        end
      end

      FINAL: begin
        if (is_last_byte(r_out.cnt)) begin
          w_out_nxt.cnt       = '0;
          w_out_nxt.round_num = '0;
          w_state_nxt         = (OUT_LATENCY == 0) ? IDLE : DRAIN;
        end else begin
          w_out_nxt.cnt = r_out.cnt + byte_idx_t'(1);
        end
      end

      DRAIN: begin
        w_out_nxt.cnt       = '0;
        w_out_nxt.round_num = '0;
        if (r_out_last) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt         = IDLE;
        w_out_nxt.cnt       = '0;
        w_out_nxt.round_num = '0;
      end
    endcase

    // Abort drops the block and clears datapath and key schedule once.
    if (w_abort) begin
      w_state_nxt         = IDLE;
      w_out_nxt.cnt       = '0;
      w_out_nxt.round_num = '0;
      w_out_nxt.rst_synch = 1'b1;
      w_out_nxt.key_start = 1'b1;
    end

    w_out_nxt.busy        = (w_state_nxt != IDLE);
    w_out_nxt.in_ready    = (w_state_nxt == LOAD);
    w_out_nxt.first_round = (w_state_nxt == LOAD);
  end

  // A slot strobe for every final-round byte, tagged last on byte 15. It is
  // taken from the next-state view so the output register below adds the
  // one cycle that makes the total delay exactly OUT_LATENCY.
  assign w_slot_in.valid = (w_state_nxt == FINAL);
  assign w_slot_in.last  = (w_state_nxt == FINAL) && is_last_byte(w_out_nxt.cnt);

  aes_valid_delay #(
    .DEPTH (OUT_LATENCY)
  ) u_valid_delay (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_abort),
    .i_slot (w_slot_in),
    .o_slot (w_slot_dly)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_out       <= CTRL_OUT_RESET;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_slot_dly.valid && !w_abort;
      r_out_last  <= w_slot_dly.last  && !w_abort;
    end
  end

  assign bus.busy                = r_out.busy;
  assign bus.in_ready            = r_out.in_ready;
  assign bus.inner_state_counter = r_out.cnt;
  assign bus.round_num           = r_out.round_num;
  assign bus.encrypt             = r_out.encrypt;
  assign bus.first_round         = r_out.first_round;
  assign bus.rst_synch           = r_out.rst_synch;
  assign bus.key_start           = r_out.key_start;
  assign bus.out_valid           = r_out_valid;
  assign bus.out_last            = r_out_last;
  assign bus.done                = r_out_last;

endmodule

// File: tb/tb_aes_round_controller.sv
// Self-checking bench for aes_round_controller. Three instances
// (10 rounds/latency 2, 14/0, 14/7) see identical stimulus; a timeline model
// predicts every output of each instance every cycle from the block's
// relative cycle number.
module tb_aes_round_controller;

  localparam int NDUT = 3;

  typedef struct packed {
    logic       busy;
    logic       in_ready;
    logic [3:0] cnt;
    logic [3:0] round_num;
    logic       encrypt;
    logic       first_round;
    logic       rst_synch;
    logic       key_start;
    logic       out_valid;
    logic       out_last;
    logic       done;
  } outs_t;

  // Model of one instance: is a block in flight, cycles since its PREP,
  // latched mode, and whether this idle cycle follows an abort.
  typedef struct {
    bit active;
    int k;
    bit enc;
    bit clr;
  } mdl_t;

  int    nr_tab  [NDUT] = '{10, 14, 14};
  int    lat_tab [NDUT] = '{2, 0, 7};
  string name_tab[NDUT] = '{"dut_a", "dut_b", "dut_c"};

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic start  = 1'b0;
  logic enc_in = 1'b1;
  logic abort  = 1'b0;

  always #5 clk = ~clk;

  aes_round_controller_if if_a ();
  aes_round_controller_if if_b ();
  aes_round_controller_if if_c ();

  assign if_a.start = start;  assign if_a.encrypt_in = enc_in;  assign if_a.abort = abort;
  assign if_b.start = start;  assign if_b.encrypt_in = enc_in;  assign if_b.abort = abort;
  assign if_c.start = start;  assign if_c.encrypt_in = enc_in;  assign if_c.abort = abort;

  aes_round_controller #(.NUM_ROUNDS(10), .OUT_LATENCY(2)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  aes_round_controller #(.NUM_ROUNDS(14), .OUT_LATENCY(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  aes_round_controller #(.NUM_ROUNDS(14), .OUT_LATENCY(7)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  outs_t obs [NDUT];
  assign obs[0] = {if_a.busy, if_a.in_ready, if_a.inner_state_counter, if_a.round_num, if_a.encrypt,
                   if_a.first_round, if_a.rst_synch, if_a.key_start, if_a.out_valid, if_a.out_last, if_a.done};
  assign obs[1] = {if_b.busy, if_b.in_ready, if_b.inner_state_counter, if_b.round_num, if_b.encrypt,
                   if_b.first_round, if_b.rst_synch, if_b.key_start, if_b.out_valid, if_b.out_last, if_b.done};
  assign obs[2] = {if_c.busy, if_c.in_ready, if_c.inner_state_counter, if_c.round_num, if_c.encrypt,
                   if_c.first_round, if_c.rst_synch, if_c.key_start, if_c.out_valid, if_c.out_last, if_c.done};

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   base     = 0;
  mdl_t mdl [NDUT];

  // Per-block observations used by the directed timing checks.
  int first_valid [NDUT];
  int n_valid     [NDUT];
  int done_cyc    [NDUT];
  int busy_fall   [NDUT];
  int n_rsync     [NDUT];
  int rsync_at    [NDUT][2];
  bit prev_busy   [NDUT];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h (block cycle %0d)", tag, observed, expected, cyc - base);
    end
  endtask

  // Relative cycle of the last out_last for a block whose PREP is k = 0.
  function automatic int last_k(input int i);
    return 16 * nr_tab[i] + 16 + lat_tab[i];
  endfunction

  // Expected outputs straight from the block timeline.
  function automatic outs_t model_outs(input int i);
    outs_t e;
    int    k;
    int    lk;
    int    p;
    e         = '0;
    e.encrypt = mdl[i].enc;
    if (!mdl[i].active) begin
      e.rst_synch = mdl[i].clr;
      e.key_start = mdl[i].clr;
    end else begin
      k      = mdl[i].k;
      lk     = last_k(i);
      e.busy = 1'b1;
      if (k == 0) begin
        e.rst_synch = 1'b1;
        e.key_start = 1'b1;
      end else if (k <= 16 * (nr_tab[i] + 1)) begin
        p           = (k - 1) / 16;
        e.cnt       = 4'((k - 1) % 16);
        e.round_num = 4'(p);
        if (p == 0) begin
          e.in_ready    = 1'b1;
          e.first_round = 1'b1;
        end
      end
      if (k >= lk - 15 && k <= lk) e.out_valid = 1'b1;
      if (k == lk) begin
        e.out_last = 1'b1;
        e.done     = 1'b1;
      end
    end
    return e;
  endfunction

  // Advance one instance's model across a rising edge.
  function automatic void model_edge(input int i);
    if (!rst) begin
      mdl[i].active = 1'b0;
      mdl[i].enc    = 1'b1;
      mdl[i].clr    = 1'b0;
    end else if (mdl[i].active) begin
      if (abort) begin
        mdl[i].active = 1'b0;
        mdl[i].clr    = 1'b1;
      end else begin
        mdl[i].k   = mdl[i].k + 1;
        mdl[i].clr = 1'b0;
        if (mdl[i].k > last_k(i)) mdl[i].active = 1'b0;
      end
    end else begin
      mdl[i].clr = 1'b0;
      if (start) begin
        mdl[i].active = 1'b1;
        mdl[i].k      = 0;
        mdl[i].enc    = enc_in;
      end
    end
  endfunction

  task automatic compare_all();
    outs_t e;
    outs_t o;
    for (int i = 0; i < NDUT; i++) begin
      e = model_outs(i);
      o = obs[i];
      check({name_tab[i], ".busy"},        32'(o.busy),        32'(e.busy));
      check({name_tab[i], ".in_ready"},    32'(o.in_ready),    32'(e.in_ready));
      check({name_tab[i], ".counter"},     32'(o.cnt),         32'(e.cnt));
      check({name_tab[i], ".round_num"},   32'(o.round_num),   32'(e.round_num));
      check({name_tab[i], ".encrypt"},     32'(o.encrypt),     32'(e.encrypt));
      check({name_tab[i], ".first_round"}, 32'(o.first_round), 32'(e.first_round));
      check({name_tab[i], ".rst_synch"},   32'(o.rst_synch),   32'(e.rst_synch));
      check({name_tab[i], ".key_start"},   32'(o.key_start),   32'(e.key_start));
      check({name_tab[i], ".out_valid"},   32'(o.out_valid),   32'(e.out_valid));
      check({name_tab[i], ".out_last"},    32'(o.out_last),    32'(e.out_last));
      check({name_tab[i], ".done"},        32'(o.done),        32'(e.done));
    end
  endtask

  task automatic update_stats();
    int rel;
    rel = cyc - base;
    for (int i = 0; i < NDUT; i++) begin
      if (obs[i].out_valid === 1'b1) begin
        if (n_valid[i] == 0) first_valid[i] = rel;
        n_valid[i]++;
      end
      if (obs[i].done === 1'b1) done_cyc[i] = rel;
      if (prev_busy[i] && obs[i].busy === 1'b0 && busy_fall[i] < 0) busy_fall[i] = rel;
      if (obs[i].rst_synch === 1'b1) begin
        if (n_rsync[i] < 2) rsync_at[i][n_rsync[i]] = rel;
        n_rsync[i]++;
      end
      prev_busy[i] = (obs[i].busy === 1'b1);
    end
  endtask

  task automatic clear_stats();
    base = cyc;
    for (int i = 0; i < NDUT; i++) begin
      first_valid[i] = -1;
      n_valid[i]     = 0;
      done_cyc[i]    = -1;
      busy_fall[i]   = -1;
      n_rsync[i]     = 0;
      rsync_at[i][0] = -1;
      rsync_at[i][1] = -1;
      prev_busy[i]   = (obs[i].busy === 1'b1);
    end
  endtask

  // One clock: model follows the edge, outputs are compared mid-cycle.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < NDUT; i++) model_edge(i);
    cyc++;
    @(negedge clk);
    compare_all();
    update_stats();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Output window and busy fall of one complete block, from the spec timeline.
  task automatic check_block(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      check({tag, ".", name_tab[i], ".first_valid"}, first_valid[i], 2 + 16 * nr_tab[i] + lat_tab[i]);
      check({tag, ".", name_tab[i], ".n_valid"},     n_valid[i],     16);
      check({tag, ".", name_tab[i], ".done_cycle"},  done_cyc[i],    17 + 16 * nr_tab[i] + lat_tab[i]);
      check({tag, ".", name_tab[i], ".busy_fall"},   busy_fall[i],   18 + 16 * nr_tab[i] + lat_tab[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < NDUT; i++) begin
      mdl[i].active = 1'b0;
      mdl[i].k      = 0;
      mdl[i].enc    = 1'b1;
      mdl[i].clr    = 1'b0;
    end
    clear_stats();

    // Reset state.
    rst = 1'b0;
    run(3);
    check("reset.busy", 32'(obs[0].busy), 0);
    check("reset.encrypt", 32'(obs[0].encrypt), 1);
    rst = 1'b1;
    run(2);

    // Single encrypt block with the default timeline.
    clear_stats();
    start  = 1'b1;
    enc_in = 1'b1;
    step();
    start = 1'b0;
    run(259);
    check_block("enc");
    check("enc.dut_a.done_at_179", done_cyc[0], 179);
    check("enc.dut_a.idle_at_180", busy_fall[0], 180);

    // Decrypt block; mode input flips and a stray start arrives mid-block.
    clear_stats();
    start  = 1'b1;
    enc_in = 1'b0;
    step();
    start = 1'b0;
    run(40);
    enc_in = 1'b1;
    start  = 1'b1;
    step();
    start = 1'b0;
    run(220);
    check_block("dec");
    check("dec.encrypt_held", 32'(obs[0].encrypt), 0);
    check("dec.single_prep", n_rsync[0], 1);

    // Back-to-back: start held high across the end of the first block.
    clear_stats();
    start  = 1'b1;
    enc_in = 1'b1;
    run(185);
    start = 1'b0;
    run(190);
    check("b2b.rsync_first", rsync_at[0][0], 1);
    check("b2b.rsync_second", rsync_at[0][1], 181);
    check("b2b.rsync_count", n_rsync[0], 2);
    check("b2b.valid_count", n_valid[0], 32);

    // Abort in round 5 at byte 7, then restart with abort still high.
    clear_stats();
    start = 1'b1;
    step();
    start = 1'b0;
    run(88);
    check("abort.at_round", 32'(obs[0].round_num), 5);
    check("abort.at_counter", 32'(obs[0].cnt), 7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort.idle", 32'(obs[0].busy), 0);
    check("abort.rst_synch", 32'(obs[0].rst_synch), 1);
    check("abort.key_start", 32'(obs[0].key_start), 1);
    step();
    check("abort.rst_synch_one_cycle", 32'(obs[0].rst_synch), 0);
    run(2);
    check("abort.no_valid", n_valid[0], 0);
    check("abort.no_done", done_cyc[0], -1);
    clear_stats();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    run(259);
    check_block("restart");

    // Reset pulse at cycle 100 of a decrypt block, with start high meanwhile.
    clear_stats();
    start  = 1'b1;
    enc_in = 1'b0;
    step();
    start = 1'b0;
    run(99);
    rst   = 1'b0;
    start = 1'b1;
    step();
    check("rst.busy", 32'(obs[0].busy), 0);
    check("rst.encrypt", 32'(obs[0].encrypt), 1);
    check("rst.rst_synch", 32'(obs[0].rst_synch), 0);
    rst   = 1'b1;
    start = 1'b0;
    run(5);
    check("rst.start_ignored", 32'(obs[0].busy), 0);

    // Randomized traffic against the timeline model.
    for (int n = 0; n < 3000; n++) begin
      start  = ($urandom_range(0, 99) < 3);
      enc_in = $urandom_range(0, 1) == 1;
      abort  = ($urandom_range(0, 999) < 2);
      rst    = !($urandom_range(0, 1999) < 1);
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b1;
    run(300);
    check("final.idle_a", 32'(obs[0].busy), 0);
    check("final.idle_c", 32'(obs[2].busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of stimulus, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
